// File: rtl/alu_pkg.sv
// Shared widths and opcode encoding for the calculator ALU.
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned RES_W = OP_W + 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MOD = 2'b11
  } op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational next-result and flag logic for the ALU.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  input  logic [1:0]       S,
  output logic [RES_W-1:0] r,
  output logic             sf,
  output logic             zf,
  output logic             dzf
);

  logic [RES_W-1:0] a_ext, b_ext;
  logic [RES_W-1:0] res;
  logic [OP_W-1:0]  a_mag, b_mag, rem_mag;
  logic [RES_W-1:0] rem_ext;
  logic             div0;
  op_e              op;

  assign op    = op_e'(S);
  assign a_ext = {A[OP_W-1], A};
  assign b_ext = {B[OP_W-1], B};

  // Magnitudes held unsigned so -4 maps cleanly to 4.
  assign a_mag = A[OP_W-1] ? (~A + 1'b1) : A;
  assign b_mag = B[OP_W-1] ? (~B + 1'b1) : B;

  always_comb begin
    rem_mag = '0;
    if (b_mag != '0) rem_mag = a_mag % b_mag;
  end

  assign rem_ext = {1'b0, rem_mag};
  assign div0    = (op == OP_MOD) && (B == '0);

  always_comb begin
    res = '0;
    unique case (op)
      OP_ADD: res = a_ext + b_ext;
      OP_SUB: res = a_ext - b_ext;
      // Low RES_W bits of the full signed product equal the product of sign-extended RES_W-bit operands.
      OP_MUL: res = a_ext * b_ext;
      OP_MOD: res = A[OP_W-1] ? (~rem_ext + 1'b1) : rem_ext;
      default: res = '0;
    endcase
  end

  always_comb begin
    r   = res;
    sf  = res[RES_W-1];
    zf  = (res == '0);
    dzf = 1'b0;
    if (div0) begin
      r   = '0;
      sf  = 1'b0;
      zf  = 1'b0;
      dzf = 1'b1;
    end
  end

endmodule

// File: rtl/alu.sv
// Registered signed ALU: combinational core feeding a synchronously reset output bank.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  input  logic [1:0]       S,
  output logic [RES_W-1:0] R,
  output logic             SF,
  output logic             ZF,
  output logic             DZF
);

  logic [RES_W-1:0] r_nxt;
  logic             sf_nxt, zf_nxt, dzf_nxt;

  alu_core u_core (
    .A   (A),
    .B   (B),
    .S   (S),
    .r   (r_nxt),
    .sf  (sf_nxt),
    .zf  (zf_nxt),
    .dzf (dzf_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      R   <= '0;
      SF  <= 1'b0;
      ZF  <= 1'b0;
      DZF <= 1'b0;
    end else begin
      R   <= r_nxt;
      SF  <= sf_nxt;
      ZF  <= zf_nxt;
      DZF <= dzf_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequence, randomized model check.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] A, B;
  logic [1:0] S;
  logic [3:0] R;
  logic       SF, ZF, DZF;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alu dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .S   (S),
    .R   (R),
    .SF  (SF),
    .ZF  (ZF),
    .DZF (DZF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] s;
    logic [3:0] r;
    logic       sf;
    logic       zf;
    logic       dzf;
  } vec_t;

  vec_t tbl[16];

  // Expected {R,SF,ZF,DZF} from integer arithmetic on the signed operand values.
  function automatic logic [6:0] model(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    int ia, ib, v;
    logic [3:0] rv;
    ia = $signed(a);
    ib = $signed(b);
    v  = 0;
    case (s)
      2'd0: v = ia + ib;
      2'd1: v = ia - ib;
      2'd2: v = ia * ib;
      default: begin
        if (ib == 0) return 7'b0000_001;
        v = ia % ib;
      end
    endcase
    rv = v[3:0];
    return {rv, rv[3], (rv == 4'd0), 1'b0};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got R/SF/ZF/DZF=%b required %b", name, got, exp);
    end
  endtask

  task automatic apply(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    @(negedge clk);
    A = a;
    B = b;
    S = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{3'b001, 3'b001, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'b111, 3'b001, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{3'b100, 3'b100, 2'b00, 4'b1000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{3'b010, 3'b011, 2'b01, 4'b1111, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{3'b111, 3'b111, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{3'b011, 3'b100, 2'b01, 4'b0111, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{3'b110, 3'b111, 2'b10, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3'b111, 3'b011, 2'b10, 4'b1101, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{3'b100, 3'b100, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{3'b100, 3'b101, 2'b10, 4'b1100, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{3'b101, 3'b011, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{3'b110, 3'b011, 2'b11, 4'b1110, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{3'b001, 3'b010, 2'b11, 4'b0001, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{3'b100, 3'b101, 2'b11, 4'b1111, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{3'b001, 3'b000, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{3'b001, 3'b000, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    A   = 3'b010;
    B   = 3'b001;
    S   = 2'b00;
    @(posedge clk);
    #1;
    check("reset_state", {R, SF, ZF, DZF}, 7'b0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].a, tbl[i].b, tbl[i].s);
      check($sformatf("vec%0d", i), {R, SF, ZF, DZF},
            {tbl[i].r, tbl[i].sf, tbl[i].zf, tbl[i].dzf});
    end
    check("mod_3_mod_neg2", model(3'b011, 3'b110, 2'b11), 7'b0001_000);

    // Reset overrides an operation issued on the same edge.
    @(negedge clk);
    A = 3'b011;
    B = 3'b011;
    S = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_discard", {R, SF, ZF, DZF}, 7'b0);
    @(negedge clk);
    rst = 1'b0;
    check("reset_hold_until_edge", {R, SF, ZF, DZF}, 7'b0);
    @(posedge clk);
    #1;
    check("first_after_reset", {R, SF, ZF, DZF}, 7'b0110_000);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] ra, rb;
      logic [1:0] rs;
      logic       rr;
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      rs = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      A = ra;
      B = rb;
      S = rs;
      rst = rr;
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", i), {R, SF, ZF, DZF}, rr ? 7'b0 : model(ra, rb, rs));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
